i2c_master: RTL and testbench
=============================

# i2c_master

Single-byte I2C bus master that generates SCL and drives SDA open-drain, addressing a 7-bit slave with one write or read transaction per request. It is the initiator for the slave devices on the same two-wire bus. It sits between the system-side request logic and the bus pins.

## Interface
- `DIV_Q`, default 4: system clocks per SCL quarter period, minimum 1. One bit period is `4*DIV_Q` clocks.
- `CLK` input, 1 bit: system clock; all logic runs on its rising edge.
- `reset` input, 1 bit: asynchronous active-low reset.
- `start` input, 1 bit: request strobe; sampled only while `busy=0`.
- `addr` input, 7 bits: slave address; captured when `start` is accepted.
- `rw` input, 1 bit: 0 = write, 1 = read; captured when `start` is accepted.
- `wdata` input, 8 bits: write byte; captured when `start` is accepted.
- `SCL` output, 1 bit: bus clock, push-pull. No clock stretching.
- `SDA` inout, 1 bit: open-drain bus data. The block drives 0 or releases to `Z`; the line reads 1 through an external pull-up.
- `busy` output, 1 bit: transaction in progress.
- `done` output, 1 bit: one-cycle pulse at the end of a transaction.
- `rdata` output, 8 bits: byte received by the last read.
- `ack_err` output, 1 bit: the last transaction saw a NACK on the address or on the write data. Valid from `done` until the next accepted `start`.

## Operation
- **Reset values:** `SCL=1`, `SDA` released, `busy=0`, `done=0`, `rdata=8'h00`, `ack_err=0`, state IDLE.
- **Request acceptance:** `start=1` with `busy=0` is accepted. On that edge `{addr,rw}` and `wdata` are latched, `ack_err` is cleared, `busy` is set, and the state becomes START. `start` is ignored while `busy=1`.
- **Bit timing (all data and ACK bits):**
  - Quarters Q0–Q1: `SCL=0`. The new SDA value is applied on the first cycle of Q0.
  - Quarters Q2–Q3: `SCL=1`. The master samples SDA on the last cycle of Q2.
- **States:**
  - **IDLE:** `SCL=1`, SDA released.
  - **START:** one bit period. Q0–Q1: `SCL=1`, SDA released. Q2–Q3: SDA=0, `SCL=1`. The start condition is SDA falling while SCL is high.
  - **ADDR:** 8 bits, MSB first: `addr[6:0]`, then `rw`.
  - **ACK_A:** SDA released; sample the ACK. A sampled 1 sets `ack_err`.
  - **WDATA:** `wdata[7:0]`, MSB first. Entered when `rw=0`.
  - **ACK_W:** SDA released; a sampled 1 sets `ack_err`.
  - **RDATA:** SDA released; 8 samples are shifted MSB first into a shift register. `rdata` updates once, after the 8th sample. Entered when `rw=1`.
  - **MNACK:** master releases SDA (NACK, reads as 1) for one bit.
  - **STOP:** one bit period. Q0–Q1: `SCL=0`, SDA=0. Q2: `SCL=1`, SDA=0. Q3: `SCL=1`, SDA released. The stop condition is SDA rising while SCL is high.
  - **DONE:** one cycle. `done=1`, `busy=0` on the next edge, then return to IDLE.
- **Counters:**
  - Bit counter: 3 bits, wraps 7→0 to end a byte.
  - Quarter/divider counter: `$clog2(4*DIV_Q)` bits, wraps at `4*DIV_Q-1`.
- **Reset asserted mid-transaction:** all outputs return immediately to their reset values. SDA is released and SCL goes to 1, and no stop condition is generated. Leaving the bus in that state is the required behaviour.

## Timing
- Full transaction (write or read): `done` is high exactly `80*DIV_Q` clocks after the acceptance edge. This covers START, 18 bits and STOP.
- `busy` rises on the acceptance edge and falls on the edge after `done`.
- `start` asserted in the same cycle as `done`: ignored. It is accepted on a later cycle once `busy=0`.
- SDA changes only while `SCL=0`, except for the start and stop conditions.

## Configuration
- **`I2C_MASTER_NACK_ABORT_EN` defined:** a NACK in ACK_A goes straight to STOP and skips the data phase. `done` then arrives `44*DIV_Q` clocks after acceptance, `ack_err=1`, and `rdata` is unchanged.
- **Undefined:** the data phase always runs. A NACK only sets `ack_err`, and timing stays at `80*DIV_Q`.

## Test plan
- **Write with ACK:** `DIV_Q=4`, `addr=7'b1100111`, `rw=0`, `wdata=8'h5A`, slave model ACKs.
  - Bus shows the start condition, then bits `11001110`, ACK, `01011010`, ACK, then stop.
  - `done` at acceptance+320 clocks, `ack_err=0`.
- **Read:** slave model returns `8'b10101010`.
  - `rdata=8'hAA`, master NACK bit is 1, `done` at +320, `ack_err=0`.
- **Address NACK** (`addr=7'h12`, no slave responds):
  - Macro undefined: `ack_err=1`, `done` at +320.
  - Macro defined: `ack_err=1`, stop condition follows the 9th bit, `done` at +176.
- **Busy protection:** pulse `start` with different `addr` and `wdata` mid-transaction.
  - The bus sequence matches the originally latched values and no second transaction occurs.
- **Reset mid-operation:** drop `reset` during WDATA bit 3.
  - Same cycle: `SCL=1`, SDA=Z, `busy=0`.
  - After release, a new write completes normally.
- **Back-to-back:** hold `start=1` continuously.
  - Transactions are accepted on the cycle after each `busy` fall, and every `done` is exactly one cycle wide.

Source files
------------

// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master
// Brief    : Single-byte I2C bus master. Generates START, 7-bit address + R/W,
//            one data byte (write or read) with ACK handling, then STOP.
//            SCL is push-pull; SDA is open-drain (drives 0 or releases).
// Options  : I2C_MASTER_NACK_ABORT_EN - address NACK skips the data phase
//            and goes straight to STOP.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_master #(
  parameter int DIV_Q = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       SCL,
  inout  wire        SDA,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ack_err
);

  localparam int QW = $clog2(4 * DIV_Q);

  // Quarter-counter landmarks within one bit period
  localparam logic [QW-1:0] c_Q_HALF   = QW'(2 * DIV_Q);      // first cycle of Q2
  localparam logic [QW-1:0] c_Q_SAMPLE = QW'(3 * DIV_Q - 1);  // last cycle of Q2
  localparam logic [QW-1:0] c_Q_THREE  = QW'(3 * DIV_Q);      // first cycle of Q3
  localparam logic [QW-1:0] c_Q_LAST   = QW'(4 * DIV_Q - 1);  // last cycle of Q3

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_START = 4'd1,
    S_ADDR  = 4'd2,
    S_ACK_A = 4'd3,
    S_WDATA = 4'd4,
    S_ACK_W = 4'd5,
    S_RDATA = 4'd6,
    S_MNACK = 4'd7,
    S_STOP  = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [QW-1:0]   r_qcnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_addr_rw;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rx;
  logic [7:0]      r_rdata;
  logic            r_ack_err;
  logic            w_scl;
  logic            w_sda_oe;
  logic            w_bit_end;
  logic            w_sample;
  logic            w_hi_phase;
  logic            w_sda_in;

  assign w_bit_end  = (r_qcnt == c_Q_LAST);
  assign w_sample   = (r_qcnt == c_Q_SAMPLE);
  assign w_hi_phase = (r_qcnt >= c_Q_HALF);
  assign w_sda_in   = SDA;

  // Open-drain pad: only ever pull low or release
  assign SDA     = w_sda_oe ? 1'b0 : 1'bz;
  assign SCL     = w_scl;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign rdata   = r_rdata;
  assign ack_err = r_ack_err;

  // State register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and bus pin decode
  always_comb begin
    w_state_nxt = r_state;
    w_scl       = 1'b1;
    w_sda_oe    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_START;
      end
      S_START: begin
        // SDA falls halfway through with SCL held high
        w_sda_oe = w_hi_phase;
        if (w_bit_end) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_scl    = w_hi_phase;
        w_sda_oe = ~r_addr_rw[3'd7 - r_bit];
        if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = S_ACK_A;
      end
      S_ACK_A: begin
        w_scl = w_hi_phase;
        if (w_bit_end) begin
`ifdef I2C_MASTER_NACK_ABORT_EN
          if (r_ack_err)         w_state_nxt = S_STOP;
          else if (r_addr_rw[0]) w_state_nxt = S_RDATA;
          else                   w_state_nxt = S_WDATA;
`else
          if (r_addr_rw[0]) w_state_nxt = S_RDATA;
          else              w_state_nxt = S_WDATA;
`endif
        end
      end
      S_WDATA: begin
        w_scl    = w_hi_phase;
        w_sda_oe = ~r_wdata[3'd7 - r_bit];
        if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = S_ACK_W;
      end
      S_ACK_W: begin
        w_scl = w_hi_phase;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_RDATA: begin
        w_scl = w_hi_phase;
        if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = S_MNACK;
      end
      S_MNACK: begin
        w_scl = w_hi_phase;
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        // SDA held low through Q2, released in Q3 while SCL is high
        w_scl    = w_hi_phase;
        w_sda_oe = (r_qcnt < c_Q_THREE);
        if (w_bit_end) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture, bit timing counters, ACK and read-data sampling
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_qcnt    <= '0;
      r_bit     <= 3'd0;
      r_addr_rw <= 8'h00;
      r_wdata   <= 8'h00;
      r_rx      <= 8'h00;
      r_rdata   <= 8'h00;
      r_ack_err <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_qcnt <= '0;
      if (start) begin
        r_addr_rw <= {addr, rw};
        r_wdata   <= wdata;
        r_ack_err <= 1'b0;
        r_bit     <= 3'd0;
      end
    end else if (r_state == S_DONE) begin
      r_qcnt <= '0;
    end else begin
      r_qcnt <= w_bit_end ? '0 : r_qcnt + 1'b1;
      // Bit counter wraps 7->0 at the end of each byte
      if (w_bit_end && ((r_state == S_ADDR) || (r_state == S_WDATA) ||
                        (r_state == S_RDATA))) begin
        r_bit <= r_bit + 3'd1;
      end
      if (w_sample) begin
        if (((r_state == S_ACK_A) || (r_state == S_ACK_W)) && w_sda_in) begin
          r_ack_err <= 1'b1;
        end
        if (r_state == S_RDATA) begin
          r_rx <= {r_rx[6:0], w_sda_in};
          if (r_bit == 3'd7) r_rdata <= {r_rx[6:0], w_sda_in};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_master
// Brief    : Directed bench for i2c_master with a bus monitor and a simple
//            slave model (ACK and read-data driver).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_master;

  localparam int DIV_Q = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr  = 7'h00;
  logic       rw    = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       scl;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ack_err;
  wire        sda;

  logic       slave_drive = 1'b0;
  assign sda = slave_drive ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_master #(.DIV_Q(DIV_Q)) u_dut (
    .CLK     (clk),
    .reset   (rst_n),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .SCL     (scl),
    .SDA     (sda),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .ack_err (ack_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Monitor / slave state
  logic [31:0] mon_bits = '0;
  int          mon_n    = 0;
  int          n_start  = 0;
  int          n_stop   = 0;
  logic        s_ack    = 1'b1;
  logic [7:0]  s_rb     = 8'h00;
  logic        s_rw     = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Bus monitor and slave model, sampled on the falling system clock edge
  initial begin
    logic scl_p;
    logic sda_p;
    int   fcnt;
    int   rcnt;
    int   idx;
    scl_p = 1'b1;
    sda_p = 1'b1;
    fcnt  = 0;
    rcnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) slave_drive = 1'b0;
      if (scl && scl_p && sda_p && !sda) begin
        n_start = n_start + 1;
        fcnt = 0;
        rcnt = 0;
      end
      if (scl && scl_p && !sda_p && sda) n_stop = n_stop + 1;
      if (scl && !scl_p) begin
        mon_bits = {mon_bits[30:0], sda};
        mon_n = mon_n + 1;
        rcnt = rcnt + 1;
        if (rcnt == 8) s_rw = sda;
      end
      if (!scl && scl_p && rst_n) begin
        fcnt = fcnt + 1;
        idx = fcnt - 1;
        if (idx == 8)                           slave_drive = s_ack;
        else if (idx >= 9 && idx <= 16 && s_rw) slave_drive = s_ack & ~s_rb[16 - idx];
        else if (idx == 17 && !s_rw)            slave_drive = s_ack;
        else                                    slave_drive = 1'b0;
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_bits = '0;
    mon_n    = 0;
    n_start  = 0;
    n_stop   = 0;
  endtask

  // Issue one request and wait (bounded) for done; lat = -1 on timeout
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         output int lat);
    int acc;
    @(negedge clk);
    clear_mon();
    addr  = a;
    rw    = r;
    wdata = wd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    lat = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - acc;
        break;
      end
    end
  endtask

  // Checks common to every completed transaction
  task automatic post_done(input string tag, input int lat, input int exp_lat,
                           input int exp_n, input logic [31:0] exp_bits);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_at_done"}, busy, 1'b1);
    check({tag, "_nbits"}, mon_n, exp_n);
    check({tag, "_bits"}, mon_bits, exp_bits);
    check({tag, "_nstart"}, n_start, 1);
    @(negedge clk);
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_nstop"}, n_stop, 1);
  endtask

  initial begin
    int lat;
    int dones;
    int last_done;
    logic prev_done;
    logic prev_busy;
    logic fell;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_ack_err", ack_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write with ACK
    s_ack = 1'b1;
    run_txn(7'b1100111, 1'b0, 8'h5A, lat);
    post_done("wr", lat, 320, 19, 32'(19'b1100111_0_0_01011010_0_0));
    check("wr_ack_err", ack_err, 1'b0);

    // Read, slave returns AA
    s_rb = 8'hAA;
    run_txn(7'b1100111, 1'b1, 8'h00, lat);
    post_done("rd", lat, 320, 19, 32'(19'b1100111_1_0_10101010_1_0));
    check("rd_rdata", rdata, 8'hAA);
    check("rd_ack_err", ack_err, 1'b0);

    // Address NACK, nobody answers
    s_ack = 1'b0;
    run_txn(7'h12, 1'b0, 8'h5A, lat);
`ifdef I2C_MASTER_NACK_ABORT_EN
    post_done("nack", lat, 176, 10, 32'(10'b0010010_0_1_0));
`else
    post_done("nack", lat, 320, 19, 32'(19'b0010010_0_1_01011010_1_0));
`endif
    check("nack_ack_err", ack_err, 1'b1);
    check("nack_rdata_kept", rdata, 8'hAA);

    // Busy protection: a second start mid-transaction must be ignored
    s_ack = 1'b1;
    fork
      run_txn(7'b0110011, 1'b0, 8'hC3, lat);
      begin
        repeat (60) @(negedge clk);
        start = 1'b1;
        addr  = 7'h7F;
        rw    = 1'b1;
        wdata = 8'hFF;
        @(negedge clk);
        start = 1'b0;
      end
    join
    post_done("busyprot", lat, 320, 19, 32'(19'b0110011_0_0_11000011_0_0));
    check("busyprot_ack_err", ack_err, 1'b0);
    repeat (50) @(negedge clk);
    check("busyprot_no_second_busy", busy, 1'b0);
    check("busyprot_no_second_start", n_start, 1);

    // Reset during WDATA bit 3 (wdata A5 has a 0 there, so SDA is driven)
    @(negedge clk);
    clear_mon();
    addr  = 7'h55;
    rw    = 1'b0;
    wdata = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (209) @(negedge clk);
    check("midrst_pre_scl", scl, 1'b0);
    check("midrst_pre_sda", sda, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_scl", scl, 1'b1);
    check("midrst_sda", sda, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(7'h55, 1'b0, 8'hA5, lat);
    post_done("afterrst", lat, 320, 19, 32'(19'b1010101_0_0_10100101_0_0));
    check("afterrst_ack_err", ack_err, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    addr  = 7'b1100111;
    rw    = 1'b0;
    wdata = 8'h5A;
    start = 1'b1;
    dones = 0;
    last_done = 0;
    prev_done = 1'b0;
    prev_busy = 1'b0;
    fell = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (prev_done) check("b2b_done_width", done, 1'b0);
      if (fell) check("b2b_reaccept", busy, 1'b1);
      fell = prev_busy && !busy;
      if (done) begin
        if (dones > 0) check("b2b_done_gap", cyc - last_done, 322);
        last_done = cyc;
        dones = dones + 1;
      end
      prev_done = done;
      prev_busy = busy;
    end
    start = 1'b0;
    check("b2b_done_count", dones, 3);
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("b2b_drain", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
